// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run sequencer: state encoding, default halt
// opcode and the default per-program start-address map.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned W_DEFAULT = 9;
    localparam logic [W_DEFAULT-1:0] HALT_CODE_DEFAULT = '1;

    // Programs are laid out in equal slices of the address space.
    function automatic int unsigned prog_base(input int unsigned idx,
                                              input int unsigned d,
                                              input int unsigned nprog);
        return idx * ((32'd1 << d) / nprog);
    endfunction

endpackage

// File: rtl/run_ctrl_prog_base_lut.sv
// Program index to start address map; swap this module to relocate programs.
module prog_base_lut
    import run_ctrl_pkg::*;
#(
    parameter int unsigned D     = 8,
    parameter int unsigned NPROG = 4,
    parameter int unsigned SW    = $clog2(NPROG)
) (
    input  logic [SW-1:0] sel,
    output logic [D-1:0]  base
);

    always_comb begin
        base = D'(prog_base(32'(sel), D, NPROG));
    end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: four-phase req/done handshake, program selection, halt and
// end-of-ROM detection, stall hold, retired-cycle counter and watchdog.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned D       = 8,
    parameter int unsigned W       = 9,
    parameter int unsigned NPROG   = 4,
    parameter int unsigned CW      = 16,
    parameter int unsigned MAX_CYC = 1024,
    parameter logic [W-1:0] HALT_CODE = {W{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [$clog2(NPROG)-1:0] prog_sel,
    input  logic [D-1:0]             prog_ctr,
    input  logic [W-1:0]             mach_code,
    input  logic                     stall,
    output logic                     pc_load,
    output logic [D-1:0]             pc_start,
    output logic                     run_en,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [CW-1:0]            cycles
);

    localparam int unsigned   SW      = $clog2(NPROG);
    localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0] CYC_SAT = '1;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] sel_q;
    logic [D-1:0]  base;
    logic          halt_hit;
    logic          rom_end;
    logic          wd_hit;
    logic          run_start;
    logic          tmo_set;

    prog_base_lut #(
        .D     (D),
        .NPROG (NPROG),
        .SW    (SW)
    ) u_prog_base_lut (
        .sel  (sel_q),
        .base (base)
    );

    assign halt_hit = (mach_code == HALT_CODE);
    assign rom_end  = (prog_ctr == {D{1'b1}});
    assign wd_hit   = (cycles == WD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and retire enable; exit priority is halt, end-of-ROM, watchdog
    always_comb begin
        state_nxt = state;
        run_en    = 1'b0;
        run_start = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOAD;
                    run_start = 1'b1;
                end
            end
            LOAD: begin
                state_nxt = req ? RUN : IDLE;
            end
            RUN: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else begin
                    run_en = ~stall & ~halt_hit;
                    if (halt_hit && !stall) begin
                        state_nxt = DONE;
                    end else if (run_en && rom_end) begin
                        state_nxt = DONE;
                    end else if (run_en && wd_hit) begin
                        state_nxt = DONE;
                        tmo_set   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered status outputs, program select and cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            pc_load <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
        end else begin
            pc_load <= (state_nxt == LOAD);
            busy    <= (state_nxt == LOAD) || (state_nxt == RUN);
            done    <= (state_nxt == DONE);
            if (run_start) begin
                sel_q   <= prog_sel;
                cycles  <= '0;
                timeout <= 1'b0;
            end else begin
                if (run_en && (cycles != CYC_SAT)) begin
                    cycles <= cycles + CW'(1);
                end
                if (tmo_set) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    // Start address is only driven while the load strobe is up
    assign pc_start = pc_load ? base : '0;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int unsigned D     = 8;
    localparam int unsigned W     = 9;
    localparam int unsigned NPROG = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned MAXC  = 10;
    localparam int unsigned SPAN  = 256 / NPROG;
    localparam logic [W-1:0] HALT = HALT_CODE_DEFAULT;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          req       = 1'b0;
    logic [1:0]    prog_sel  = 2'd0;
    logic [D-1:0]  prog_ctr  = '0;
    logic [W-1:0]  mach_code = '0;
    logic          stall     = 1'b0;
    logic          pc_load;
    logic [D-1:0]  pc_start;
    logic          run_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    run_ctrl #(
        .D(D), .W(W), .NPROG(NPROG), .CW(CW), .MAX_CYC(MAXC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
        .prog_ctr(prog_ctr), .mach_code(mach_code), .stall(stall),
        .pc_load(pc_load), .pc_start(pc_start), .run_en(run_en),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic cyc(input int r, input int pc, input int mc, input int st, input int rs = 0);
        @(posedge clk);
        #1;
        req       = 1'(r);
        prog_ctr  = D'(pc);
        mach_code = W'(mc);
        stall     = 1'(st);
        reset     = 1'(rs);
    endtask

    // Behavioural model: where the run is, how many instructions retired
    bit loading, running, finished, wd_end;
    int retired, sel_m;

    always @(posedge clk) begin
        if (reset) begin
            loading = 0; running = 0; finished = 0; wd_end = 0; retired = 0;
        end else if (loading) begin
            loading = 0;
            running = req;
        end else if (running) begin
            if (!req) begin
                running = 0;
            end else if (!stall) begin
                if (mach_code == HALT) begin
                    running = 0; finished = 1;
                end else begin
                    retired++;
                    if (prog_ctr == 8'hFF) begin
                        running = 0; finished = 1;
                    end else if (retired == int'(MAXC)) begin
                        running = 0; finished = 1; wd_end = 1;
                    end
                end
            end
        end else if (finished) begin
            if (!req) finished = 0;
        end else if (req) begin
            loading = 1; sel_m = int'(prog_sel); retired = 0; wd_end = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_pc_load", pc_load, loading);
            check("m_busy", busy, loading | running);
            check("m_done", done, finished);
            check("m_timeout", timeout, wd_end);
            check("m_cycles", cycles, retired);
            check("m_run_en", run_en, running && req && !stall && (mach_code != HALT));
            if (loading) check("m_pc_start", pc_start, sel_m * SPAN);
        end
    end

    // Request, load, then n retires (optional stall window), then halt
    task automatic run_halt(input int sel, input int n, input int st_at, input int st_len);
        prog_sel = 2'(sel);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); #5;
        check("load_strobe", pc_load, 1);
        check("load_start", pc_start, sel * SPAN);
        check("load_cycles", cycles, 0);
        for (int i = 0; i < n; i++) begin
            if (i == st_at) begin
                for (int s = 0; s < st_len; s++) begin
                    cyc(1, sel * SPAN + i, i + 1, 1); #5;
                    check("stall_run_en", run_en, 0);
                    check("stall_hold", cycles, i);
                    check("stall_no_done", done, 0);
                end
            end
            cyc(1, sel * SPAN + i, i + 1, 0); #5;
            check("retire_en", run_en, 1);
        end
        cyc(1, sel * SPAN + n, HALT, 0); #5;
        check("halt_run_en", run_en, 0);
        check("halt_no_done", done, 0);
        cyc(1, 0, 0, 0); #5;
        check("halt_done", done, 1);
        check("halt_cycles", cycles, n);
        check("halt_timeout", timeout, 0);
        check("halt_busy", busy, 0);
    endtask

    task automatic release_req();
        cyc(0, 0, 0, 0); #5;
        check("rel_done_held", done, 1);
        cyc(0, 0, 0, 0); #5;
        check("rel_done_fall", done, 0);
        check("rel_busy", busy, 0);
    endtask

    initial begin
        int i;
        bit rq;
        // Reset
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0); #5;
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_start", pc_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cycles", cycles, 0);

        // Halt path, then with a 4-cycle stall mid-run
        run_halt(1, 3, -1, 0);
        release_req();
        run_halt(1, 3, 2, 4);
        release_req();

        // Watchdog
        prog_sel = 2'd0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (i = 0; i < 30; i++) begin
            cyc(1, i, 5, 0); #5;
            if (done) break;
        end
        check("wd_done", done, 1);
        check("wd_latency", i, MAXC);
        check("wd_timeout", timeout, 1);
        check("wd_cycles", cycles, MAXC);
        release_req();

        // End-of-ROM retires a normal instruction
        prog_sel = 2'd3;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 192, 1, 0);
        cyc(1, 193, 2, 0);
        cyc(1, 255, 7, 0); #5;
        check("eor_run_en", run_en, 1);
        cyc(1, 0, 0, 0); #5;
        check("eor_done", done, 1);
        check("eor_cycles", cycles, 3);
        check("eor_timeout", timeout, 0);
        release_req();

        // End-of-ROM with halt: halt wins, not counted
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 192, 1, 0);
        cyc(1, 255, HALT, 0); #5;
        check("eorh_run_en", run_en, 0);
        cyc(1, 0, 0, 0); #5;
        check("eorh_done", done, 1);
        check("eorh_cycles", cycles, 1);
        release_req();

        // End-of-ROM on the watchdog cycle: no timeout
        prog_sel = 2'd0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int k = 0; k < int'(MAXC) - 1; k++) cyc(1, k, 3, 0);
        cyc(1, 255, 3, 0);
        cyc(1, 0, 0, 0); #5;
        check("eorwd_done", done, 1);
        check("eorwd_timeout", timeout, 0);
        check("eorwd_cycles", cycles, MAXC);
        release_req();

        // Abort in RUN, restart, hold req after done
        prog_sel = 2'd2;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 128, 1, 0);
        cyc(1, 129, 2, 0);
        cyc(0, 130, 5, 0); #5;
        check("abort_run_en", run_en, 0);
        cyc(0, 0, 0, 0); #5;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cycles", cycles, 2);
        run_halt(2, 1, -1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0); #5;
            check("hold_done", done, 1);
        end
        release_req();

        // Reset in the middle of a run
        prog_sel = 2'd1;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 7; k++) cyc(1, 64 + k, 4, 0);
        cyc(1, 71, 4, 0, 1); #5;
        check("mid_cycles", cycles, 7);
        cyc(1, 0, 0, 0); #5;
        check("mrst_pc_load", pc_load, 0);
        check("mrst_pc_start", pc_start, 0);
        check("mrst_run_en", run_en, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_timeout", timeout, 0);
        check("mrst_cycles", cycles, 0);
        cyc(1, 0, 0, 0); #5;
        check("mrst_reload", pc_load, 1);
        check("mrst_start", pc_start, 64);

        // Randomized traffic against the model
        rq = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 11) == 0) rq = ~rq;
            prog_sel = 2'($urandom_range(0, 3));
            cyc(rq,
                ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 254),
                ($urandom_range(0, 9) == 0) ? int'(HALT) : $urandom_range(0, 510),
                ($urandom_range(0, 3) == 0) ? 1 : 0,
                ($urandom_range(0, 199) == 0) ? 1 : 0);
        end
        cyc(0, 0, 0, 0);
        @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
